// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and an iterative
// unsigned multiply/divide unit that stalls the front end while it runs.
module ex_stage #(
  parameter int XLEN    = 32,
  parameter int MD_ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_ex_RegWrite_i,
  input  logic            id_ex_MemToReg_i,
  input  logic            id_ex_Branch_i,
  input  logic            id_ex_MemRead_i,
  input  logic            id_ex_MemWrite_i,
  input  logic [1:0]      id_ex_ALUop_i,
  input  logic [1:0]      id_ex_ALUsrc_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] rd2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [6:0]      ALUctrl_funct7_i,
  input  logic [2:0]      ALUctrl_funct3_i,
  input  logic [4:0]      wr_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic            fwd_mem_RegWrite_i,
  input  logic [4:0]      fwd_mem_wr_i,
  input  logic [XLEN-1:0] fwd_mem_data_i,
  input  logic            fwd_wb_RegWrite_i,
  input  logic [4:0]      fwd_wb_wr_i,
  input  logic [XLEN-1:0] fwd_wb_data_i,
  output logic            stall_o,
  output logic            ex_mem_RegWrite_o,
  output logic            ex_mem_MemToReg_o,
  output logic            ex_mem_MemRead_o,
  output logic            ex_mem_MemWrite_o,
  output logic            ex_mem_branch_taken_o,
  output logic [XLEN-1:0] ex_mem_branch_target_o,
  output logic [XLEN-1:0] ex_mem_alu_result_o,
  output logic [XLEN-1:0] ex_mem_store_data_o,
  output logic [4:0]      ex_mem_wr_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(MD_ITER);

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] md_acc, md_a, md_b;
  logic [2:0]      md_f3;

  logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_res, md_res;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic [4:0]      shamt;
  logic            alt, br_cond, md_op, md_iter;

  function automatic logic hit(input logic we, input logic [4:0] wr, input logic [4:0] rs);
    return we && (wr != 5'd0) && (wr == rs);
  endfunction

  // MEM is the younger producer, so it wins over WB; x0 never forwards.
  assign fwd_a = hit(fwd_mem_RegWrite_i, fwd_mem_wr_i, rs1_i) ? fwd_mem_data_i :
                 hit(fwd_wb_RegWrite_i,  fwd_wb_wr_i,  rs1_i) ? fwd_wb_data_i  : rd1_i;
  assign fwd_b = hit(fwd_mem_RegWrite_i, fwd_mem_wr_i, rs2_i) ? fwd_mem_data_i :
                 hit(fwd_wb_RegWrite_i,  fwd_wb_wr_i,  rs2_i) ? fwd_wb_data_i  : rd2_i;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    op_a = fwd_a;
    op_b = fwd_b;
    case (id_ex_ALUsrc_i)
      2'b01:   op_b = imm_i;
      2'b10:   begin op_a = pc_i; op_b = imm_i; end
      2'b11:   begin op_a = pc_i; op_b = XLEN'(4); end
      default: ;
    endcase
  end

  assign md_op   = (id_ex_ALUop_i == 2'b10) && (ALUctrl_funct7_i == 7'b0000001);
  assign md_iter = md_op && ((ALUctrl_funct3_i == 3'b000) || (ALUctrl_funct3_i == 3'b101) ||
                             (ALUctrl_funct3_i == 3'b111));

  // I-type ALU only honours funct7[5] for SRAI; funct7 of other I-types is immediate bits.
  assign alt   = ALUctrl_funct7_i[5] && ((id_ex_ALUop_i == 2'b10) || (ALUctrl_funct3_i == 3'b101));
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (id_ex_ALUop_i)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      default:
        if (!md_op) begin
          case (ALUctrl_funct3_i)
            3'b000: alu_res = alt ? (op_a - op_b) : (op_a + op_b);
            3'b001: alu_res = op_a << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            3'b100: alu_res = op_a ^ op_b;
            3'b101: alu_res = alt ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
            3'b110: alu_res = op_a | op_b;
            default: alu_res = op_a & op_b;
          endcase
        end
    endcase
  end

  always_comb begin
    case (ALUctrl_funct3_i)
      3'b000:  br_cond = (op_a == op_b);
      3'b001:  br_cond = (op_a != op_b);
      3'b100:  br_cond = ($signed(op_a) < $signed(op_b));
      3'b101:  br_cond = ($signed(op_a) >= $signed(op_b));
      3'b110:  br_cond = (op_a < op_b);
      3'b111:  br_cond = (op_a >= op_b);
      default: br_cond = 1'b0;
    endcase
  end

  // Restoring division step: md_acc is the partial remainder, md_a shifts the
  // dividend out and the quotient in. A zero divisor naturally yields all-ones
  // quotient and the dividend as remainder.
  assign rem_sh   = {md_acc, md_a[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, md_b};
  assign md_res   = (md_f3 == 3'b101) ? md_a : md_acc;

  assign stall_o = ((state == S_IDLE) && md_iter) || (state == S_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the datapath registers are reset too so an aborted operation leaves nothing behind.
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      md_acc <= '0;
      md_a   <= '0;
      md_b   <= '0;
      md_f3  <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (md_iter) begin
            // Forwarding sources drain during the stall, so operands are captured now.
            state  <= S_BUSY;
            cnt    <= CW'(MD_ITER - 1);
            md_acc <= '0;
            md_a   <= op_a;
            md_b   <= op_b;
            md_f3  <= ALUctrl_funct3_i;
          end
        S_BUSY: begin
          if (md_f3 == 3'b000) begin
            if (md_b[0]) md_acc <= md_acc + md_a;
            md_a <= md_a << 1;
            md_b <= md_b >> 1;
          end else if (!rem_diff[XLEN]) begin
            md_acc <= rem_diff[XLEN-1:0];
            md_a   <= {md_a[XLEN-2:0], 1'b1};
          end else begin
            md_acc <= rem_sh[XLEN-1:0];
            md_a   <= {md_a[XLEN-2:0], 1'b0};
          end
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || stall_o) begin
      ex_mem_RegWrite_o      <= 1'b0;
      ex_mem_MemToReg_o      <= 1'b0;
      ex_mem_MemRead_o       <= 1'b0;
      ex_mem_MemWrite_o      <= 1'b0;
      ex_mem_branch_taken_o  <= 1'b0;
      ex_mem_branch_target_o <= '0;
      ex_mem_alu_result_o    <= '0;
      ex_mem_store_data_o    <= '0;
      ex_mem_wr_o            <= '0;
    end else begin
      ex_mem_RegWrite_o      <= id_ex_RegWrite_i;
      ex_mem_MemToReg_o      <= id_ex_MemToReg_i;
      ex_mem_MemRead_o       <= id_ex_MemRead_i;
      ex_mem_MemWrite_o      <= id_ex_MemWrite_i;
      ex_mem_branch_taken_o  <= id_ex_Branch_i && (id_ex_ALUop_i == 2'b01) && br_cond;
      ex_mem_branch_target_o <= pc_i + imm_i;
      ex_mem_alu_result_o    <= (state == S_DONE) ? md_res : alu_res;
      ex_mem_store_data_o    <= fwd_b;
      ex_mem_wr_o            <= wr_i;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage: a driver issues instructions and
// queues the model's expected EX/MEM contents; a monitor pops and compares.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_ex_RegWrite_i, id_ex_MemToReg_i, id_ex_Branch_i, id_ex_MemRead_i, id_ex_MemWrite_i;
  logic [1:0]  id_ex_ALUop_i, id_ex_ALUsrc_i;
  logic [31:0] pc_i, rd1_i, rd2_i, imm_i;
  logic [6:0]  ALUctrl_funct7_i;
  logic [2:0]  ALUctrl_funct3_i;
  logic [4:0]  wr_i, rs1_i, rs2_i;
  logic        fwd_mem_RegWrite_i, fwd_wb_RegWrite_i;
  logic [4:0]  fwd_mem_wr_i, fwd_wb_wr_i;
  logic [31:0] fwd_mem_data_i, fwd_wb_data_i;
  logic        stall_o;
  logic        ex_mem_RegWrite_o, ex_mem_MemToReg_o, ex_mem_MemRead_o, ex_mem_MemWrite_o;
  logic        ex_mem_branch_taken_o;
  logic [31:0] ex_mem_branch_target_o, ex_mem_alu_result_o, ex_mem_store_data_o;
  logic [4:0]  ex_mem_wr_o;

  typedef struct {
    logic        regwrite, memtoreg, branch, memread, memwrite;
    logic [1:0]  aluop, alusrc;
    logic [31:0] pc, rd1, rd2, imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  wr, rs1, rs2;
    logic        mrw, wrw;
    logic [4:0]  mwr, wwr;
    logic [31:0] mdata, wdata;
  } instr_t;

  typedef struct {
    logic        regwrite, memtoreg, memread, memwrite, taken;
    logic [31:0] target, result, store;
    logic        chk_store;
    logic [4:0]  wr;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   in_valid = 1'b0;
  bit   mon_pv = 1'b0;
  bit   mon_ps = 1'b0;

  ex_stage #(.XLEN(32), .MD_ITER(32)) dut (
    .clk(clk), .rst(rst),
    .id_ex_RegWrite_i(id_ex_RegWrite_i), .id_ex_MemToReg_i(id_ex_MemToReg_i),
    .id_ex_Branch_i(id_ex_Branch_i), .id_ex_MemRead_i(id_ex_MemRead_i),
    .id_ex_MemWrite_i(id_ex_MemWrite_i), .id_ex_ALUop_i(id_ex_ALUop_i),
    .id_ex_ALUsrc_i(id_ex_ALUsrc_i), .pc_i(pc_i), .rd1_i(rd1_i), .rd2_i(rd2_i),
    .imm_i(imm_i), .ALUctrl_funct7_i(ALUctrl_funct7_i), .ALUctrl_funct3_i(ALUctrl_funct3_i),
    .wr_i(wr_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .fwd_mem_RegWrite_i(fwd_mem_RegWrite_i), .fwd_mem_wr_i(fwd_mem_wr_i),
    .fwd_mem_data_i(fwd_mem_data_i), .fwd_wb_RegWrite_i(fwd_wb_RegWrite_i),
    .fwd_wb_wr_i(fwd_wb_wr_i), .fwd_wb_data_i(fwd_wb_data_i), .stall_o(stall_o),
    .ex_mem_RegWrite_o(ex_mem_RegWrite_o), .ex_mem_MemToReg_o(ex_mem_MemToReg_o),
    .ex_mem_MemRead_o(ex_mem_MemRead_o), .ex_mem_MemWrite_o(ex_mem_MemWrite_o),
    .ex_mem_branch_taken_o(ex_mem_branch_taken_o),
    .ex_mem_branch_target_o(ex_mem_branch_target_o),
    .ex_mem_alu_result_o(ex_mem_alu_result_o), .ex_mem_store_data_o(ex_mem_store_data_o),
    .ex_mem_wr_o(ex_mem_wr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf, input instr_t i);
    if (i.mrw && i.mwr != 0 && i.mwr == rs) return i.mdata;
    if (i.wrw && i.wwr != 0 && i.wwr == rs) return i.wdata;
    return rf;
  endfunction

  function automatic exp_t model(input instr_t i);
    exp_t e;
    logic [31:0] a0, b0, a, b, r;
    logic c;
    int sh;
    a0 = fwd(i.rs1, i.rd1, i);
    b0 = fwd(i.rs2, i.rd2, i);
    a = (i.alusrc[1]) ? i.pc : a0;
    b = (i.alusrc == 2'b00) ? b0 : (i.alusrc == 2'b11) ? 32'd4 : i.imm;
    sh = int'(b % 32);
    r = 0; c = 0;
    e.stalls = 0; e.chk_store = 1'b1;
    if (i.aluop == 2'b00) r = a + b;
    else if (i.aluop == 2'b01) begin
      r = a - b;
      case (i.f3)
        3'd0: c = (a == b);
        3'd1: c = (a != b);
        3'd4: c = ($signed(a) < $signed(b));
        3'd5: c = !($signed(a) < $signed(b));
        3'd6: c = (a < b);
        3'd7: c = !(a < b);
        default: c = 0;
      endcase
    end else if (i.aluop == 2'b10 && i.f7 == 7'h01) begin
      case (i.f3)
        3'd0: r = a * b;
        3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd7: r = (b == 0) ? a : a % b;
        default: r = 0;
      endcase
      if (i.f3 == 3'd0 || i.f3 == 3'd5 || i.f3 == 3'd7) begin
        e.stalls = 33;
        e.chk_store = 1'b0;
      end
    end else begin
      case (i.f3)
        3'd0: r = (i.aluop == 2'b10 && i.f7[5]) ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 1 : 0;
        3'd3: r = (a < b) ? 1 : 0;
        3'd4: r = a ^ b;
        3'd5: r = i.f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    e.result = r;
    e.taken = i.branch && (i.aluop == 2'b01) && c;
    e.target = i.pc + i.imm;
    e.store = b0;
    e.regwrite = i.regwrite; e.memtoreg = i.memtoreg;
    e.memread = i.memread; e.memwrite = i.memwrite; e.wr = i.wr;
    return e;
  endfunction

  // ---------------- stimulus ----------------
  function automatic instr_t base();
    instr_t i;
    i = '{default: '0};
    return i;
  endfunction

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.regwrite = 1'($urandom); i.memtoreg = 1'($urandom); i.branch = 1'($urandom);
    i.memread = 1'($urandom); i.memwrite = 1'($urandom);
    i.aluop = 2'($urandom); i.alusrc = 2'($urandom);
    case ($urandom_range(0, 3))
      0: i.f7 = 7'h00;
      1: i.f7 = 7'h20;
      2: i.f7 = 7'h01;
      default: i.f7 = 7'($urandom);
    endcase
    if (i.aluop == 2'b10 && i.f7 == 7'h01) i.alusrc = 2'b00;
    i.f3 = 3'($urandom);
    i.pc = $urandom & 32'hFFFF_FFFC; i.rd1 = rval(); i.rd2 = rval(); i.imm = rval();
    i.wr = 5'($urandom); i.rs1 = 5'($urandom_range(0, 3)); i.rs2 = 5'($urandom_range(0, 3));
    i.mrw = 1'($urandom); i.mwr = 5'($urandom_range(0, 3)); i.mdata = rval();
    i.wrw = 1'($urandom); i.wwr = 5'($urandom_range(0, 3)); i.wdata = rval();
    return i;
  endfunction

  task automatic drive(input instr_t i);
    id_ex_RegWrite_i = i.regwrite; id_ex_MemToReg_i = i.memtoreg; id_ex_Branch_i = i.branch;
    id_ex_MemRead_i = i.memread; id_ex_MemWrite_i = i.memwrite;
    id_ex_ALUop_i = i.aluop; id_ex_ALUsrc_i = i.alusrc;
    pc_i = i.pc; rd1_i = i.rd1; rd2_i = i.rd2; imm_i = i.imm;
    ALUctrl_funct7_i = i.f7; ALUctrl_funct3_i = i.f3;
    wr_i = i.wr; rs1_i = i.rs1; rs2_i = i.rs2;
    fwd_mem_RegWrite_i = i.mrw; fwd_mem_wr_i = i.mwr; fwd_mem_data_i = i.mdata;
    fwd_wb_RegWrite_i = i.wrw; fwd_wb_wr_i = i.wwr; fwd_wb_data_i = i.wdata;
  endtask

  // Issue one instruction into ID/EX, hold it while stalled, and after the
  // operands are latched corrupt the forwarding data as a draining pipe would.
  task automatic issue_exp(input instr_t i, input exp_t e);
    int n;
    @(posedge clk); #1;
    drive(i);
    in_valid = 1'b1;
    sb.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall_o) break;
      n++;
      if (n == 2) begin
        fwd_mem_data_i = ~fwd_mem_data_i;
        fwd_wb_data_i  = fwd_wb_data_i ^ 32'h5A5A_A5A5;
      end
      if (n >= 200) break;
    end
    check("stall_len", 128'(n), 128'(e.stalls));
  endtask

  task automatic issue(input instr_t i);
    issue_exp(i, model(i));
  endtask

  task automatic issue_lit(input instr_t i, input logic [31:0] res, input logic taken);
    exp_t e;
    e = model(i);
    e.result = res;
    e.taken = taken;
    issue_exp(i, e);
  endtask

  function automatic logic [127:0] all_outs();
    return {ex_mem_RegWrite_o, ex_mem_MemToReg_o, ex_mem_MemRead_o, ex_mem_MemWrite_o,
            ex_mem_branch_taken_o, ex_mem_branch_target_o, ex_mem_alu_result_o,
            ex_mem_store_data_o, ex_mem_wr_o};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_pv = 1'b0;
      end else begin
        if (mon_pv && mon_ps) begin
          check("bubble_ctrl", {ex_mem_RegWrite_o, ex_mem_MemToReg_o, ex_mem_MemRead_o,
                                ex_mem_MemWrite_o, ex_mem_branch_taken_o}, 0);
          check("bubble_data", {ex_mem_alu_result_o, ex_mem_store_data_o,
                                ex_mem_branch_target_o, ex_mem_wr_o}, 0);
        end else if (mon_pv) begin
          if (sb.size() == 0) check("unexpected_output", 1, 0);
          else begin
            e = sb.pop_front();
            check("ctrl", {ex_mem_RegWrite_o, ex_mem_MemToReg_o, ex_mem_MemRead_o, ex_mem_MemWrite_o},
                  {e.regwrite, e.memtoreg, e.memread, e.memwrite});
            check("taken", ex_mem_branch_taken_o, e.taken);
            check("target", ex_mem_branch_target_o, e.target);
            check("result", ex_mem_alu_result_o, e.result);
            check("wr", ex_mem_wr_o, e.wr);
            if (e.chk_store) check("store", ex_mem_store_data_o, e.store);
          end
        end
        mon_pv = in_valid;
        mon_ps = stall_o;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    instr_t i;
    rst = 1'b1;
    drive(base());
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    check("reset_stall", stall_o, 0);
    rst = 1'b0;

    // ADD x3 = x1 + x2
    i = base(); i.regwrite = 1; i.aluop = 2'b10; i.rd1 = 5; i.rd2 = 7;
    i.rs1 = 1; i.rs2 = 2; i.wr = 3;
    issue_lit(i, 32'd12, 1'b0);

    // forwarding priority and the x0 rule
    i = base(); i.regwrite = 1; i.wr = 5; i.rs1 = 4; i.rd1 = 32'h99;
    i.mrw = 1; i.mwr = 4; i.mdata = 32'h10; i.wrw = 1; i.wwr = 4; i.wdata = 32'h20;
    issue_lit(i, 32'h10, 1'b0);
    i.mrw = 0;
    issue_lit(i, 32'h20, 1'b0);
    i.mrw = 1; i.rs1 = 0;
    issue_lit(i, 32'h99, 1'b0);
    i.mwr = 0; i.wwr = 0;
    issue_lit(i, 32'h99, 1'b0);

    // BLT / BLTU with A=-1, B=1
    i = base(); i.branch = 1; i.aluop = 2'b01; i.f3 = 3'b100;
    i.rd1 = 32'hFFFF_FFFF; i.rd2 = 1; i.imm = 8; i.pc = 32'h100;
    issue_lit(i, 32'hFFFF_FFFE, 1'b1);
    check("blt_target_seen", ex_mem_branch_target_o, 0);
    i.f3 = 3'b110;
    issue_lit(i, 32'hFFFF_FFFE, 1'b0);

    // reset in the middle of a multiply, ten iterations in
    @(posedge clk); #1;
    i = base(); i.regwrite = 1; i.aluop = 2'b10; i.f7 = 7'h01; i.rd1 = 32'h0001_0003; i.rd2 = 5;
    drive(i); in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b1;
    drive(base());
    #1;
    check("midop_reset_outputs", all_outs(), 0);
    check("midop_reset_stall", stall_o, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("post_reset_stall", stall_o, 0);

    // multiply/divide directed cases
    i = base(); i.regwrite = 1; i.wr = 9; i.aluop = 2'b10; i.f7 = 7'h01;
    i.rd1 = 32'h0001_0003; i.rd2 = 5;
    issue_lit(i, 32'h0005_000F, 1'b0);
    i.f3 = 3'b101; i.rd1 = 100; i.rd2 = 7;
    issue_lit(i, 32'd14, 1'b0);
    i.f3 = 3'b111;
    issue_lit(i, 32'd2, 1'b0);
    i.f3 = 3'b101; i.rd1 = 32'h1234_5678; i.rd2 = 0;
    issue_lit(i, 32'hFFFF_FFFF, 1'b0);
    i.f3 = 3'b111; i.rd1 = 9;
    issue_lit(i, 32'd9, 1'b0);
    i.f3 = 3'b011;
    issue_lit(i, 32'd0, 1'b0);
    // operands come through forwarding and must survive the draining pipe
    i.f3 = 3'b000; i.rs1 = 2; i.rs2 = 3; i.mrw = 1; i.mwr = 2; i.mdata = 32'd1000;
    i.wrw = 1; i.wwr = 3; i.wdata = 32'd77;
    issue_lit(i, 32'd77000, 1'b0);

    for (int k = 0; k < 120; k++) issue(rand_instr());

    @(posedge clk); #1;
    drive(base()); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline. Directly consumes the ID/EX pipeline register outputs and produces the EX/MEM pipeline register.
- Contains operand forwarding, ALU, branch resolution and an iterative unsigned multiply/divide unit.
- Stalls the front end while the multiply/divide unit is busy.

Parameters:
- XLEN, 32, datapath width
- MD_ITER, 32, multiply/divide iterations (must equal XLEN)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- id_ex_RegWrite_i, id_ex_MemToReg_i, id_ex_Branch_i, id_ex_MemRead_i, id_ex_MemWrite_i  in  1 each  control from ID/EX
- id_ex_ALUop_i  in  2  00 add, 01 branch compare, 10 R-type, 11 I-type ALU
- id_ex_ALUsrc_i  in  2  00 A=rs1,B=rs2; 01 A=rs1,B=imm; 10 A=pc,B=imm; 11 A=pc,B=4
- pc_i, rd1_i, rd2_i, imm_i  in  32 each  from ID/EX
- ALUctrl_funct7_i  in  7  instruction funct7
- ALUctrl_funct3_i  in  3  instruction funct3
- wr_i, rs1_i, rs2_i  in  5 each  destination and source register numbers
- fwd_mem_RegWrite_i  in  1  RegWrite of instruction now in MEM
- fwd_mem_wr_i  in  5  destination register of instruction now in MEM
- fwd_mem_data_i  in  32  ALU result of instruction now in MEM
- fwd_wb_RegWrite_i  in  1  RegWrite of instruction now in WB
- fwd_wb_wr_i  in  5  destination register of instruction now in WB
- fwd_wb_data_i  in  32  write-back data of instruction now in WB
- stall_o  out  1  combinational; PC, IF/ID and ID/EX hold while high
- ex_mem_RegWrite_o, ex_mem_MemToReg_o, ex_mem_MemRead_o, ex_mem_MemWrite_o  out  1 each  registered control
- ex_mem_branch_taken_o  out  1  registered; Branch and condition true
- ex_mem_branch_target_o  out  32  registered pc_i+imm_i
- ex_mem_alu_result_o  out  32  registered result
- ex_mem_store_data_o  out  32  registered forwarded rs2 value
- ex_mem_wr_o  out  5  registered destination register

Behaviour:
- Reset (async): all outputs 0, multiply/divide FSM to IDLE, counter 0.
- Forwarding, per source register:
  - The MEM source is used if fwd_mem_RegWrite_i, fwd_mem_wr_i != 0 and fwd_mem_wr_i == rs; otherwise the WB source under the same rule; otherwise rd1_i/rd2_i.
  - MEM has priority over WB. x0 is never forwarded.
- ALU:
  - ALUop 00: A+B.
  - ALUop 10: funct3/funct7[5] select ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is B[4:0].
  - ALUop 11: same selection, but funct7[5] is honoured only for SRAI (funct3=101).
- Branch compare (ALUop 01), funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu. Other codes give not-taken. alu_result is A-B.
- Multiply/divide applies when ALUop=10 and funct7=0000001:
  - funct3 000 is MUL (low 32 bits), 101 is DIVU, 111 is REMU. Each is iterative shift-add or restoring division.
  - Other M funct3 values give result 0 in a single cycle with no stall.
- FSM IDLE, BUSY, DONE:
  - IDLE, M op present: latch forwarded operands, counter=MD_ITER-1, go to BUSY. stall_o=1.
  - BUSY: one iteration per cycle, stall_o=1. At counter==0 go to DONE, else decrement.
  - DONE: stall_o=0, result is presented and EX/MEM captures it at this edge. Go to IDLE.
  - Total: M op sits in EX for 34 cycles (1 IDLE + 32 BUSY + 1 DONE), with stall_o high for 33.
- Operands are latched at start because forwarding sources drain during the stall.
- Divide by zero: DIVU returns 0xFFFFFFFF; REMU returns the dividend. No exception is raised.
- While stall_o=1, EX/MEM loads a bubble: all control outputs 0, data don't-care but held at 0.
- Otherwise EX/MEM loads every posedge.
- Reset mid-operation aborts the FSM with no partial result.

Test Plan:
- Reset asserted during BUSY at iteration 10 -> all outputs 0 immediately, FSM IDLE, stall_o=0 after release.
- ADD x3=x1+x2 with rd1_i=5, rd2_i=7 and no forwarding -> next edge ex_mem_alu_result_o=12, ex_mem_RegWrite_o=1, ex_mem_wr_o=3.
- Forwarding priority, rs1=4:
  - fwd_mem (wr=4, data=0x10) and fwd_wb (wr=4, data=0x20) both valid -> A=0x10.
  - Same with rs1=0 -> A=rd1_i.
- BLT with A=0xFFFFFFFF, B=1, imm=8, pc=0x100 -> branch_taken=1, target=0x108. BLTU with the same operands -> taken=0.
- MUL 0x00010003 * 0x00000005:
  - stall_o high exactly 33 cycles, bubbles in EX/MEM meanwhile.
  - Result 0x0005000F is captured on the 34th edge.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
